io_write_arbiter: RTL and testbench

Two-master arbiter in front of the memory-mapped output-port register bank. It shares the single write path (addr, data, write enable) between requester 0 (CPU store path) and requester 1 (secondary master, e.g. debug/loader). Round-robin grant, valid/ack handshake, address-range check, and a programmable idle gap between successive writes for slow external displays.

---
 rtl/io_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_io_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: shares the single output-port write path between
// requester 0 (CPU store path) and requester 1 (debug/loader master).
// Round-robin grant, one-cycle WRITE with ack pulse, address-range check,
// and an optional programmable idle gap after every accepted write.
// Optional build macro IO_ARB_LOCK_EN adds lock0/lock1 inputs that let the
// current winner keep the grant across ties.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; winner's addr/data latched on exit
// S_WRITE | one cycle: ack to winner, io_wen (in range) or err (not)
// S_GAP   | forced idle cycles after a write; requests not accepted
module io_write_arbiter #(
    parameter logic [5:0] PORT_BASE     = 6'b100000,
    parameter int         NUM_OUT_PORTS = 2,
    parameter int         GAP_CYCLES    = 0
) (
    input  logic        io_clk,
    input  logic        clrn,
`ifdef IO_ARB_LOCK_EN
    input  logic        lock0,
    input  logic        lock1,
`endif
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic [31:0] io_addr,
    output logic [31:0] io_datas,
    output logic        io_wen,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [6:0] PORT_LO  = {1'b0, PORT_BASE};
    localparam logic [6:0] PORT_HI  = 7'(int'(PORT_BASE) + NUM_OUT_PORTS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_grant;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_datas;
    logic [3:0]  r_gap_cnt;
    logic        w_load;
    logic        w_winner;
    logic        w_hold;
    logic [6:0]  w_port;
    logic        w_in_range;

`ifdef IO_ARB_LOCK_EN
    logic r_lock;

    // Remember whether the winner asked to keep the grant for the next tie.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn)
            r_lock <= 1'b0;
        else if (r_state == S_WRITE)
            r_lock <= r_last_grant ? lock1 : lock0;
    end

    assign w_hold = r_lock;
`else
    assign w_hold = 1'b0;
`endif

    // Winner selection: a lone requester wins; on a tie the requester that
    // was not granted last wins, unless the previous winner holds a lock.
    always_comb begin
        w_winner = 1'b0;
        if (req1 && !req0)
            w_winner = 1'b1;
        else if (req0 && req1)
            w_winner = w_hold ? r_last_grant : ~r_last_grant;
    end

    // Port-word range check on the latched address; only bits [7:2] count.
    assign w_port     = {1'b0, r_io_addr[7:2]};
    assign w_in_range = (w_port >= PORT_LO) && (w_port <= PORT_HI);

    // Next-state and handshake outputs; pulses only ever asserted in S_WRITE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        io_wen       = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_load       = 1'b1;
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                ack0         = ~r_last_grant;
                ack1         = r_last_grant;
                io_wen       = w_in_range;
                err          = ~w_in_range;
                w_next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Latch the winner's write and remember who was granted.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_io_addr    <= 32'd0;
            r_io_datas   <= 32'd0;
            r_last_grant <= 1'b1;
        end else if (w_load) begin
            r_io_addr    <= w_winner ? addr1 : addr0;
            r_io_datas   <= w_winner ? data1 : data0;
            r_last_grant <= w_winner;
        end
    end

    // Gap down-counter: loaded on leaving WRITE, exits GAP at zero.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn)
            r_gap_cnt <= 4'd0;
        else if (r_state == S_WRITE)
            r_gap_cnt <= GAP_LOAD;
        else if (r_state == S_GAP && r_gap_cnt != 4'd0)
            r_gap_cnt <= r_gap_cnt - 4'd1;
    end

    assign io_addr  = r_io_addr;
    assign io_datas = r_io_datas;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_io_write_arbiter.sv
// Bench for io_write_arbiter: one instance with no gap, one with a 3-cycle
// gap, both sharing the same request inputs.
module tb_io_write_arbiter;

    logic        io_clk;
    logic        clrn;
    logic        req0, req1;
    logic [31:0] addr0, data0, addr1, data1;
`ifdef IO_ARB_LOCK_EN
    logic        lock0, lock1;
`endif

    logic        a_ack0, a_ack1, a_wen, a_err, a_busy;
    logic [31:0] a_addr, a_data;
    logic        b_ack0, b_ack1, b_wen, b_err, b_busy;
    logic [31:0] b_addr, b_data;

    int n_chk = 0;
    int n_err = 0;

    io_write_arbiter #(.PORT_BASE(6'b100000), .NUM_OUT_PORTS(2), .GAP_CYCLES(0)) dut0 (
        .io_clk(io_clk), .clrn(clrn),
`ifdef IO_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(a_ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(a_ack1),
        .io_addr(a_addr), .io_datas(a_data), .io_wen(a_wen), .err(a_err), .busy(a_busy)
    );

    io_write_arbiter #(.PORT_BASE(6'b100000), .NUM_OUT_PORTS(2), .GAP_CYCLES(3)) dut3 (
        .io_clk(io_clk), .clrn(clrn),
`ifdef IO_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(b_ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(b_ack1),
        .io_addr(b_addr), .io_datas(b_data), .io_wen(b_wen), .err(b_err), .busy(b_busy)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_wen;
        logic        e_err;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef IO_ARB_LOCK_EN
        lock0 = 1'b0;
        lock1 = 1'b0;
`endif
        clrn = 1'b0;
        #3;
        check("rst io_addr", a_addr, 32'h0);
        check("rst io_datas", a_data, 32'h0);
        check("rst io_wen", {31'd0, a_wen}, 32'h0);
        check("rst ack0", {31'd0, a_ack0}, 32'h0);
        check("rst ack1", {31'd0, a_ack1}, 32'h0);
        check("rst err", {31'd0, a_err}, 32'h0);
        check("rst busy", {31'd0, a_busy}, 32'h0);
        check("rst gap busy", {31'd0, b_busy}, 32'h0);
        @(negedge io_clk);
        clrn = 1'b1;
    endtask

    initial begin
        clrn  = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 32'h0;
        data0 = 32'h0;
        addr1 = 32'h0;
        data1 = 32'h0;
`ifdef IO_ARB_LOCK_EN
        lock0 = 1'b0;
        lock1 = 1'b0;
`endif
        //            r0  a0            d0            r1  a1          d1           ack0  ack1  wen   err   addr          data
        vecs[0] = '{1'b1, 32'h80,       32'h1234,     1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h80,       32'h1234};
        vecs[1] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h90,   32'hBAD,  1'b0, 1'b1, 1'b0, 1'b1, 32'h90,       32'hBAD};
        vecs[2] = '{1'b1, 32'h84,       32'hA,        1'b1, 32'h80,   32'hB,    1'b1, 1'b0, 1'b1, 1'b0, 32'h84,       32'hA};
        vecs[3] = '{1'b1, 32'h7C,       32'hC,        1'b1, 32'h84,   32'hD,    1'b0, 1'b1, 1'b1, 1'b0, 32'h84,       32'hD};
        vecs[4] = '{1'b1, 32'h88,       32'h5,        1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h88,       32'h5};
        vecs[5] = '{1'b1, 32'h7C,       32'h6,        1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h7C,       32'h6};
        vecs[6] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h184,  32'h77,   1'b0, 1'b1, 1'b1, 1'b0, 32'h184,      32'h77};
        vecs[7] = '{1'b1, 32'h83,       32'h99,       1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h83,       32'h99};
        vecs[8] = '{1'b1, 32'h80,       32'h11,       1'b1, 32'h85,   32'h55,   1'b0, 1'b1, 1'b1, 1'b0, 32'h85,       32'h55};
        vecs[9] = '{1'b1, 32'hFFFFFF80, 32'h66,       1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80, 32'h66};

        #2;
        do_reset();

        // Table: one request pattern per vector, WRITE cycle then IDLE cycle.
        for (int i = 0; i < 10; i++) begin
            req0  = vecs[i].r0;
            addr0 = vecs[i].a0;
            data0 = vecs[i].d0;
            req1  = vecs[i].r1;
            addr1 = vecs[i].a1;
            data1 = vecs[i].d1;
            step();
            check($sformatf("v%0d ack0", i), {31'd0, a_ack0}, {31'd0, vecs[i].e_ack0});
            check($sformatf("v%0d ack1", i), {31'd0, a_ack1}, {31'd0, vecs[i].e_ack1});
            check($sformatf("v%0d io_wen", i), {31'd0, a_wen}, {31'd0, vecs[i].e_wen});
            check($sformatf("v%0d err", i), {31'd0, a_err}, {31'd0, vecs[i].e_err});
            check($sformatf("v%0d io_addr", i), a_addr, vecs[i].e_addr);
            check($sformatf("v%0d io_datas", i), a_data, vecs[i].e_data);
            check($sformatf("v%0d busy", i), {31'd0, a_busy}, 32'h1);
            req0 = 1'b0;
            req1 = 1'b0;
            step();
            check($sformatf("v%0d idle pulses", i), {28'd0, a_wen, a_ack0, a_ack1, a_err}, 32'h0);
            check($sformatf("v%0d idle busy", i), {31'd0, a_busy}, 32'h0);
            check($sformatf("v%0d idle addr hold", i), a_addr, vecs[i].e_addr);
        end

        // Contention: both held, grants alternate 0,1,0,1 every other cycle.
        do_reset();
        req0 = 1'b1; addr0 = 32'h80; data0 = 32'hAAAA_0000;
        req1 = 1'b1; addr1 = 32'h84; data1 = 32'hBBBB_0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) begin
                check($sformatf("cont%0d wen", k), {31'd0, a_wen}, 32'h1);
                check($sformatf("cont%0d ack0", k), {31'd0, a_ack0}, (k % 4 == 1) ? 32'h1 : 32'h0);
                check($sformatf("cont%0d ack1", k), {31'd0, a_ack1}, (k % 4 == 3) ? 32'h1 : 32'h0);
                check($sformatf("cont%0d data", k), a_data, (k % 4 == 1) ? 32'hAAAA_0000 : 32'hBBBB_0000);
            end else begin
                check($sformatf("cont%0d idle", k), {29'd0, a_wen, a_ack0, a_ack1}, 32'h0);
            end
        end

        // Gap spacing: req0 held; gap-3 instance writes every 5 cycles.
        do_reset();
        req0 = 1'b1; addr0 = 32'h84; data0 = 32'h0000_C0DE;
        req1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("gap%0d wen", k), {31'd0, b_wen}, (k % 5 == 1) ? 32'h1 : 32'h0);
            check($sformatf("gap%0d ack0", k), {31'd0, b_ack0}, (k % 5 == 1) ? 32'h1 : 32'h0);
            check($sformatf("gap%0d busy", k), {31'd0, b_busy}, (k % 5 != 0) ? 32'h1 : 32'h0);
            check($sformatf("gap%0d nogap wen", k), {31'd0, a_wen}, (k % 2 == 1) ? 32'h1 : 32'h0);
        end
        check("gap data", b_data, 32'h0000_C0DE);

        // Reset during WRITE clears outputs at once; next tie goes to requester 0.
        do_reset();
        req0 = 1'b1; addr0 = 32'h80; data0 = 32'h0000_00AA;
        req1 = 1'b1; addr1 = 32'h84; data1 = 32'h0000_00BB;
        step();
        check("mid wen before", {31'd0, a_wen}, 32'h1);
        #2;
        clrn = 1'b0;
        #1;
        check("mid wen", {31'd0, a_wen}, 32'h0);
        check("mid ack0", {31'd0, a_ack0}, 32'h0);
        check("mid io_addr", a_addr, 32'h0);
        check("mid io_datas", a_data, 32'h0);
        check("mid busy", {31'd0, a_busy}, 32'h0);
        @(negedge io_clk);
        clrn = 1'b1;
        step();
        check("post rst ack0", {31'd0, a_ack0}, 32'h1);
        check("post rst ack1", {31'd0, a_ack1}, 32'h0);
        check("post rst data", a_data, 32'h0000_00AA);

`ifdef IO_ARB_LOCK_EN
        // Lock: requester 0 keeps the grant while lock0 is high.
        do_reset();
        req0 = 1'b1; addr0 = 32'h80; data0 = 32'hA;
        req1 = 1'b1; addr1 = 32'h84; data1 = 32'hB;
        lock0 = 1'b1;
        for (int k = 1; k <= 7; k += 2) begin
            step();
            check($sformatf("lock%0d ack0", k), {31'd0, a_ack0}, (k <= 5) ? 32'h1 : 32'h0);
            check($sformatf("lock%0d ack1", k), {31'd0, a_ack1}, (k == 7) ? 32'h1 : 32'h0);
            if (k == 5)
                lock0 = 1'b0;
            step();
        end
`endif

        req0 = 1'b0;
        req1 = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
